// File: rtl/mio_bus_unit.sv
// Memory/I-O bus unit: turns controller strobes into a req/ack bus cycle,
// positions store data, aligns/extends load data, and reports completion
// via a one-cycle mio_ready pulse. Misaligned accesses and bus timeouts
// finish without a bus cycle result and raise a sticky bus_err.
//
// Bus handshake: ram_req is raised with ram_we/ram_be/ram_addr/ram_wdata
// already valid and all of them stay stable until ram_ack is sampled high
// on a rising edge; that edge completes the transfer (ram_rdata is taken on
// the same edge). There is no back-pressure on the controller side: the
// controller holds its strobes until mio_ready, and inputs are only looked
// at in IDLE.
module mio_bus_unit #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              cpu_mio,
   input  logic [2:0]        ram_ctrl,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              mio_ready,
   output logic              bus_err,
   output logic              ram_req,
   output logic              ram_we,
   output logic [3:0]        ram_be,
   output logic [ADDR_W-3:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   input  logic              ram_ack
);

   localparam int            TW     = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

   // state_q is the observable FSM state for hierarchical checkers
   state_t              state_q, state_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                mio_ready_q, mio_ready_d;
   logic                bus_err_q, bus_err_d;
   logic                ram_req_q, ram_req_d;
   logic                ram_we_q, ram_we_d;
   logic [3:0]          ram_be_q, ram_be_d;
   logic [ADDR_W-3:0]   ram_addr_q, ram_addr_d;
   logic [31:0]         ram_wdata_q, ram_wdata_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [2:0]          type_q, type_d;
   logic                half_sel_q, half_sel_d;

   logic                accept;
   logic                in_half, in_fullx, misaligned;
   logic [15:0]         st_half;
   logic [31:0]         st_data;
   logic [3:0]          st_be;
   logic                ld_half_t, ld_fullx, ld_signed;
   logic [15:0]         ld_half;
   logic [31:0]         ld_data;
   logic                timeout_hit;

   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // Request decode and store-data positioning for the incoming access;
   // 010..101 are the half types, 11x falls back to plain Full
   always_comb begin
      accept     = cpu_mio & (mem_read | mem_write);
      in_half    = ram_ctrl[2] ^ ram_ctrl[1];
      in_fullx   = (ram_ctrl == 3'b001);
      misaligned = in_half ? addr[0] : (addr[1:0] != 2'b00);
      st_half    = ram_ctrl[0] ? {wdata[7:0], wdata[15:8]} : wdata[15:0];
      if (in_half) begin
         st_data = {st_half, st_half};
         st_be   = addr[1] ? 4'b1100 : 4'b0011;
      end else begin
         st_data = in_fullx ? bswap32(wdata) : wdata;
         st_be   = 4'b1111;
      end
   end

   // Load-data alignment using the type and half select latched at accept
   always_comb begin
      ld_half_t = type_q[2] ^ type_q[1];
      ld_fullx  = (type_q == 3'b001);
      ld_signed = (type_q[2:1] == 2'b01);
      ld_half   = half_sel_q ? ram_rdata[31:16] : ram_rdata[15:0];
      if (type_q[0]) ld_half = {ld_half[7:0], ld_half[15:8]};
      if (ld_half_t) begin
         ld_data = ld_signed ? {{16{ld_half[15]}}, ld_half} : {16'h0000, ld_half};
      end else begin
         ld_data = ld_fullx ? bswap32(ram_rdata) : ram_rdata;
      end
      timeout_hit = (timer_q == T_LAST);
   end

   // State register and all output/context flops; reset overrides any access
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rdata_q     <= '0;
         mio_ready_q <= 1'b0;
         bus_err_q   <= 1'b0;
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_be_q    <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         timer_q     <= '0;
         type_q      <= '0;
         half_sel_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         mio_ready_q <= mio_ready_d;
         bus_err_q   <= bus_err_d;
         ram_req_q   <= ram_req_d;
         ram_we_q    <= ram_we_d;
         ram_be_q    <= ram_be_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         timer_q     <= timer_d;
         type_q      <= type_d;
         half_sel_q  <= half_sel_d;
      end
   end

   // Next-state: an ack on the timeout cycle still counts as completion
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = misaligned ? DONE : REQ;
         REQ:     if (ram_ack || timeout_hit) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/context updates; mio_ready is high exactly while in DONE
   always_comb begin
      rdata_d     = rdata_q;
      bus_err_d   = bus_err_q;
      ram_req_d   = ram_req_q;
      ram_we_d    = ram_we_q;
      ram_be_d    = ram_be_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      timer_d     = timer_q;
      type_d      = type_q;
      half_sel_d  = half_sel_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               type_d     = ram_ctrl;
               half_sel_d = addr[1];
               bus_err_d  = misaligned;
               timer_d    = '0;
               if (!misaligned) begin
                  ram_req_d   = 1'b1;
                  ram_we_d    = mem_write;
                  ram_be_d    = st_be;
                  ram_addr_d  = addr[ADDR_W-1:2];
                  ram_wdata_d = st_data;
               end
            end
         end
         REQ: begin
            timer_d = timer_q + TW'(1);
            if (ram_ack || timeout_hit) begin
               ram_req_d = 1'b0;
               ram_we_d  = 1'b0;
               ram_be_d  = 4'b0000;
               if (ram_ack) begin
                  if (!ram_we_q) rdata_d = ld_data;
               end else begin
                  bus_err_d = 1'b1;
               end
            end
         end
         DONE:    timer_d = '0;
         default: timer_d = '0;
      endcase
      mio_ready_d = (state_d == DONE);
   end

   assign rdata     = rdata_q;
   assign mio_ready = mio_ready_q;
   assign bus_err   = bus_err_q;
   assign ram_req   = ram_req_q;
   assign ram_we    = ram_we_q;
   assign ram_be    = ram_be_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mio_bus_unit.sv
// Directed bench for mio_bus_unit: a scripted bus responder with
// configurable wait states, and per-scenario tasks with hand-computed
// expectations.
module tb_mio_bus_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_read = 1'b0, mem_write = 1'b0, cpu_mio = 1'b0;
   logic [2:0]  ram_ctrl = 3'b000;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        mio_ready, bus_err, ram_req, ram_we;
   logic [3:0]  ram_be;
   logic [29:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = '0;
   logic        ram_ack = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // observations from the last run_access
   int          lat_o;
   int          req_cycles_o;
   logic [3:0]  be_o;
   logic [31:0] wd_o;
   logic [29:0] addr_o;
   logic        we_o;
   logic [31:0] exp_rdata;

   mio_bus_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .cpu_mio(cpu_mio), .ram_ctrl(ram_ctrl), .addr(addr), .wdata(wdata),
      .rdata(rdata), .mio_ready(mio_ready), .bus_err(bus_err),
      .ram_req(ram_req), .ram_we(ram_we), .ram_be(ram_be),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ram_ack(ram_ack)
   );

   // clock
   always #5 clk = ~clk;

   // One controller access plus bus responder. Acks after 'waits' request
   // cycles unless never_ack. lat_o = rising edges from accept until
   // mio_ready is seen, -1 if it never arrives within the budget.
   task automatic run_access(input logic rd, input logic wr, input logic [2:0] ctrl,
                             input logic [31:0] a, input logic [31:0] wd, input int waits,
                             input logic [31:0] bus_data, input bit never_ack);
      bit done = 0;
      @(negedge clk);
      cpu_mio = 1'b1; mem_read = rd; mem_write = wr;
      ram_ctrl = ctrl; addr = a; wdata = wd;
      @(posedge clk);
      lat_o = -1; req_cycles_o = 0;
      be_o = 'x; wd_o = 'x; addr_o = 'x; we_o = 1'bx;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (i == 0) begin
            cpu_mio = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
         end
         ram_ack = 1'b0;
         if (mio_ready) begin
            done = 1;
            lat_o = i + 1;
         end else if (ram_req) begin
            if (req_cycles_o == 0) begin
               be_o = ram_be; wd_o = ram_wdata; addr_o = ram_addr; we_o = ram_we;
            end
            req_cycles_o++;
            if (!never_ack && req_cycles_o > waits) begin
               ram_ack = 1'b1;
               ram_rdata = bus_data;
            end
         end
      end
      ram_ack = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++; if (ram_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", ram_req); end
      vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", ram_we); end
      vectors++; if (ram_be !== 4'h0) begin miscompares++; $display("FAIL reset_be: got %h want 0", ram_be); end
      vectors++; if (ram_addr !== 30'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
      vectors++; if (ram_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", ram_wdata); end
      vectors++; if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", rdata); end
      vectors++; if (mio_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", mio_ready); end
      vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", bus_err); end
      rst = 1'b0;
      exp_rdata = 32'h0;
   endtask

   task automatic test_word_read();
      run_access(1, 0, 3'b000, 32'h10, 32'h0, 0, 32'hA1B2C3D4, 0);
      exp_rdata = 32'hA1B2C3D4;
      vectors++; if (addr_o !== 30'h4) begin miscompares++; $display("FAIL wr_addr: got %h want 4", addr_o); end
      vectors++; if (be_o !== 4'b1111) begin miscompares++; $display("FAIL wr_be: got %b want 1111", be_o); end
      vectors++; if (we_o !== 1'b0) begin miscompares++; $display("FAIL wr_we: got %b want 0", we_o); end
      vectors++; if (lat_o != 2) begin miscompares++; $display("FAIL wr_latency: got %0d want 2", lat_o); end
      vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL wr_rdata: got %h want %h", rdata, exp_rdata); end
      vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL wr_err: got %b want 0", bus_err); end
      @(negedge clk);
      vectors++; if (mio_ready !== 1'b0) begin miscompares++; $display("FAIL wr_pulse_width: got %b want 0", mio_ready); end
      vectors++; if (ram_req !== 1'b0) begin miscompares++; $display("FAIL wr_req_drop: got %b want 0", ram_req); end
      // Fullx load reverses all four bytes
      run_access(1, 0, 3'b001, 32'h14, 32'h0, 0, 32'hA1B2C3D4, 0);
      exp_rdata = 32'hD4C3B2A1;
      vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL fullx_rdata: got %h want %h", rdata, exp_rdata); end
   endtask

   task automatic test_half_loads();
      logic [2:0]  ctl[5];
      logic [31:0] adr[5];
      logic [31:0] exp[5];
      ctl = '{3'b010, 3'b100, 3'b011, 3'b101, 3'b010};
      adr = '{32'h22, 32'h22, 32'h22, 32'h20, 32'h20};
      exp = '{32'hFFFF8001, 32'h00008001, 32'h00000180, 32'h0000027F, 32'h00007F02};
      for (int k = 0; k < 5; k++) begin
         run_access(1, 0, ctl[k], adr[k], 32'h0, 3, 32'h80017F02, 0);
         exp_rdata = exp[k];
         vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL half_load_%0d: got %h want %h", k, rdata, exp_rdata); end
         vectors++; if (lat_o != 5) begin miscompares++; $display("FAIL half_latency_%0d: got %0d want 5", k, lat_o); end
         vectors++; if (be_o !== (adr[k][1] ? 4'b1100 : 4'b0011)) begin miscompares++; $display("FAIL half_be_%0d: got %b", k, be_o); end
      end
   endtask

   task automatic test_stores();
      logic [2:0]  ctl[4];
      logic [31:0] adr[4];
      logic [31:0] wd[4];
      logic [31:0] exp_wd[4];
      logic [3:0]  exp_be[4];
      ctl    = '{3'b011, 3'b001, 3'b010, 3'b000};
      adr    = '{32'h46, 32'h48, 32'h44, 32'h50};
      wd     = '{32'h00001234, 32'h11223344, 32'hABCD5678, 32'hDEADBEEF};
      exp_wd = '{32'h34123412, 32'h44332211, 32'h56785678, 32'hDEADBEEF};
      exp_be = '{4'b1100, 4'b1111, 4'b0011, 4'b1111};
      for (int k = 0; k < 4; k++) begin
         // read strobe also asserted on the last one: write must win
         run_access(k == 3, 1, ctl[k], adr[k], wd[k], 1, 32'hFFFFFFFF, 0);
         vectors++; if (we_o !== 1'b1) begin miscompares++; $display("FAIL st_we_%0d: got %b want 1", k, we_o); end
         vectors++; if (be_o !== exp_be[k]) begin miscompares++; $display("FAIL st_be_%0d: got %b want %b", k, be_o, exp_be[k]); end
         vectors++; if (wd_o !== exp_wd[k]) begin miscompares++; $display("FAIL st_wdata_%0d: got %h want %h", k, wd_o, exp_wd[k]); end
         vectors++; if (addr_o !== adr[k][31:2]) begin miscompares++; $display("FAIL st_addr_%0d: got %h want %h", k, addr_o, adr[k][31:2]); end
         vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL st_rdata_kept_%0d: got %h want %h", k, rdata, exp_rdata); end
         vectors++; if (lat_o != 3) begin miscompares++; $display("FAIL st_latency_%0d: got %0d want 3", k, lat_o); end
      end
   endtask

   task automatic test_misaligned();
      int seen;
      run_access(1, 0, 3'b000, 32'h13, 32'h0, 0, 32'h55555555, 0);
      vectors++; if (req_cycles_o != 0) begin miscompares++; $display("FAIL mis_full_req: got %0d cycles want 0", req_cycles_o); end
      vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL mis_full_err: got %b want 1", bus_err); end
      vectors++; if (lat_o != 1) begin miscompares++; $display("FAIL mis_full_ready: got %0d want 1", lat_o); end
      vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL mis_full_rdata: got %h want %h", rdata, exp_rdata); end
      repeat (3) @(negedge clk);
      vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL mis_err_sticky: got %b want 1", bus_err); end
      // unqualified strobe (cpu_mio low) is not an access
      mem_read = 1'b1; addr = 32'h30; seen = 0;
      repeat (4) begin @(negedge clk); if (ram_req || mio_ready) seen++; end
      mem_read = 1'b0;
      vectors++; if (seen != 0) begin miscompares++; $display("FAIL unqualified: got %0d active cycles want 0", seen); end
      // aligned request clears the error
      run_access(1, 0, 3'b000, 32'h14, 32'h0, 0, 32'h0BADF00D, 0);
      exp_rdata = 32'h0BADF00D;
      vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL mis_err_clear: got %b want 0", bus_err); end
      vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL mis_next_rdata: got %h want %h", rdata, exp_rdata); end
      // odd half address is misaligned; a half at addr[1:0]=2 is not (checked above)
      run_access(1, 0, 3'b100, 32'h21, 32'h0, 0, 32'h55555555, 0);
      vectors++; if (req_cycles_o != 0 || bus_err !== 1'b1) begin miscompares++; $display("FAIL mis_half: got %0d cycles err %b want 0 cycles err 1", req_cycles_o, bus_err); end
   endtask

   task automatic test_timeout();
      run_access(1, 0, 3'b000, 32'h60, 32'h0, 0, 32'h0, 1);
      vectors++; if (req_cycles_o != 16) begin miscompares++; $display("FAIL to_req_cycles: got %0d want 16", req_cycles_o); end
      vectors++; if (lat_o != 17) begin miscompares++; $display("FAIL to_ready: got %0d want 17", lat_o); end
      vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL to_err: got %b want 1", bus_err); end
      vectors++; if (ram_req !== 1'b0) begin miscompares++; $display("FAIL to_req_drop: got %b want 0", ram_req); end
      vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL to_rdata: got %h want %h", rdata, exp_rdata); end
      // ack on the 16th request cycle wins over the timeout
      run_access(1, 0, 3'b000, 32'h64, 32'h0, 15, 32'h13572468, 0);
      exp_rdata = 32'h13572468;
      vectors++; if (req_cycles_o != 16) begin miscompares++; $display("FAIL late_ack_cycles: got %0d want 16", req_cycles_o); end
      vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL late_ack_err: got %b want 0", bus_err); end
      vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL late_ack_rdata: got %h want %h", rdata, exp_rdata); end
      vectors++; if (lat_o != 17) begin miscompares++; $display("FAIL late_ack_ready: got %0d want 17", lat_o); end
   endtask

   task automatic test_reset_mid_req();
      @(negedge clk);
      cpu_mio = 1'b1; mem_read = 1'b1; ram_ctrl = 3'b000; addr = 32'h70;
      @(posedge clk);
      @(negedge clk);
      cpu_mio = 1'b0; mem_read = 1'b0;
      vectors++; if (ram_req !== 1'b1) begin miscompares++; $display("FAIL mid_req_up: got %b want 1", ram_req); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_rdata = 32'h0;
      vectors++; if (ram_req !== 1'b0) begin miscompares++; $display("FAIL mid_rst_req: got %b want 0", ram_req); end
      vectors++; if (mio_ready !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 0", mio_ready); end
      vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL mid_rst_rdata: got %h want 0", rdata); end
      vectors++; if (ram_be !== 4'h0 || ram_addr !== 30'h0) begin miscompares++; $display("FAIL mid_rst_bus: got be %b addr %h want 0", ram_be, ram_addr); end
      run_access(1, 0, 3'b010, 32'h22, 32'h0, 1, 32'h80017F02, 0);
      exp_rdata = 32'hFFFF8001;
      vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL post_rst_rdata: got %h want %h", rdata, exp_rdata); end
      vectors++; if (lat_o != 3) begin miscompares++; $display("FAIL post_rst_latency: got %0d want 3", lat_o); end
   endtask

   task automatic test_back_to_back();
      run_access(1, 0, 3'b000, 32'h80, 32'h0, 0, 32'h01020304, 0);
      run_access(1, 0, 3'b001, 32'h84, 32'h0, 0, 32'h01020304, 0);
      exp_rdata = 32'h04030201;
      vectors++; if (rdata !== exp_rdata) begin miscompares++; $display("FAIL b2b_rdata: got %h want %h", rdata, exp_rdata); end
      vectors++; if (addr_o !== 30'h21) begin miscompares++; $display("FAIL b2b_addr: got %h want 21", addr_o); end
   endtask

   initial begin
      test_reset();
      test_word_read();
      test_half_loads();
      test_stores();
      test_misaligned();
      test_timeout();
      test_reset_mid_req();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
